// File: rtl/qam4_pkg.sv
// Shared definitions for the QAM4 frame mapper: default sizes, Gray codes
// for the four constellation points, and the mapper FSM state encoding.
package qam4_pkg;

    localparam int QAM4_WORD_SIZE = 16;
    localparam int QAM4_N_SYM     = 16;

    // Gray-coded bit pairs {b1,b0} selecting each ROM constellation point
    localparam logic [1:0] GRAY_CP1 = 2'b00;
    localparam logic [1:0] GRAY_CP2 = 2'b01;
    localparam logic [1:0] GRAY_CP3 = 2'b11;
    localparam logic [1:0] GRAY_CP4 = 2'b10;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/qam4_symbol_buffer.sv
// Frame buffer: N_SYM entries of packed {re,im}, cleared by reset, one
// synchronous write port and one combinational read port.
module qam4_symbol_buffer #(
    parameter int N_SYM = 16,
    parameter int WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_en,
    input  logic [$clog2(N_SYM)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(N_SYM)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] mem_q [N_SYM];

    // Store a mapped symbol; reset wipes every entry so no stale frame survives
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_SYM; i++) begin
                mem_q[i] <= '0;
            end
        end else if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/qam4_frame_mapper.sv
// QAM4 frame mapper: Gray-maps serial bit pairs onto ROM constellation
// points, collects a frame of N_SYM symbols, then streams the frame out.
module qam4_frame_mapper
    import qam4_pkg::*;
#(
    parameter int WORD_SIZE   = QAM4_WORD_SIZE,
    parameter int N_SYM       = QAM4_N_SYM,
    parameter int FRAME_CNT_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_bit,
    input  logic                     i_bit_valid,
    output logic                     o_bit_ready,
    input  logic [WORD_SIZE-1:0]     i_cp1_re,
    input  logic [WORD_SIZE-1:0]     i_cp1_im,
    input  logic [WORD_SIZE-1:0]     i_cp2_re,
    input  logic [WORD_SIZE-1:0]     i_cp2_im,
    input  logic [WORD_SIZE-1:0]     i_cp3_re,
    input  logic [WORD_SIZE-1:0]     i_cp3_im,
    input  logic [WORD_SIZE-1:0]     i_cp4_re,
    input  logic [WORD_SIZE-1:0]     i_cp4_im,
    output logic [WORD_SIZE-1:0]     o_sym_re,
    output logic [WORD_SIZE-1:0]     o_sym_im,
    output logic [$clog2(N_SYM)-1:0] o_sym_idx,
    output logic                     o_sym_valid,
    output logic                     o_sym_last,
    input  logic                     i_sym_ready,
    output logic [FRAME_CNT_W-1:0]   o_frame_cnt
);

    localparam int                PTR_W    = $clog2(N_SYM);
    localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(N_SYM - 1);

    state_e                   state_q, state_d;
    logic [PTR_W-1:0]         wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]         rdPtr_q, rdPtr_d;
    logic                     phase_q, phase_d;
    logic                     b1_q, b1_d;
    logic [FRAME_CNT_W-1:0]   frameCnt_q, frameCnt_d;

    logic                     bitReady;
    logic                     symValid;
    logic                     bitAccept;
    logic                     pairDone;
    logic                     symXfer;
    logic                     lastRead;
    logic [WORD_SIZE-1:0]     mappedRe;
    logic [WORD_SIZE-1:0]     mappedIm;
    logic [2*WORD_SIZE-1:0]   rdData;

    assign bitAccept = i_bit_valid & bitReady;
    assign pairDone  = bitAccept & phase_q;
    assign symXfer   = symValid & i_sym_ready;
    assign lastRead  = (rdPtr_q == LAST_IDX);

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave FILL when the last entry is written, leave DRAIN on the last transfer
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (pairDone && (wrPtr_q == LAST_IDX)) state_d = DRAIN;
            DRAIN:   if (symXfer && lastRead) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // FSM outputs; the input side stays closed while reset is held
    always_comb begin
        bitReady = 1'b0;
        symValid = 1'b0;
        case (state_q)
            FILL:    bitReady = i_rst_n;
            DRAIN:   symValid = 1'b1;
            default: ;
        endcase
    end

    // Gray-map the pair completing this cycle: stored b1 plus the incoming bit as b0
    always_comb begin
        mappedRe = i_cp1_re;
        mappedIm = i_cp1_im;
        case ({b1_q, i_bit})
            GRAY_CP1: begin mappedRe = i_cp1_re; mappedIm = i_cp1_im; end
            GRAY_CP2: begin mappedRe = i_cp2_re; mappedIm = i_cp2_im; end
            GRAY_CP3: begin mappedRe = i_cp3_re; mappedIm = i_cp3_im; end
            GRAY_CP4: begin mappedRe = i_cp4_re; mappedIm = i_cp4_im; end
            default:  ;
        endcase
    end

    // Pointer, pair-phase and frame-counter updates; pointers wrap because N_SYM is a power of two
    always_comb begin
        phase_d    = phase_q;
        b1_d       = b1_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        frameCnt_d = frameCnt_q;
        if (bitAccept) begin
            if (!phase_q) begin
                b1_d    = i_bit;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
        end
        if (symXfer) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
            if (lastRead) begin
                frameCnt_d = frameCnt_q + FRAME_CNT_W'(1);
            end
        end
    end

    // Datapath registers; reset drops any half-collected pair and the frame count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase_q    <= 1'b0;
            b1_q       <= 1'b0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            frameCnt_q <= '0;
        end else begin
            phase_q    <= phase_d;
            b1_q       <= b1_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            frameCnt_q <= frameCnt_d;
        end
    end

    qam4_symbol_buffer #(
        .N_SYM (N_SYM),
        .WIDTH (2 * WORD_SIZE)
    ) u_buffer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (pairDone),
        .i_wr_addr (wrPtr_q),
        .i_wr_data ({mappedRe, mappedIm}),
        .i_rd_addr (rdPtr_q),
        .o_rd_data (rdData)
    );

    assign o_bit_ready = bitReady;
    assign o_sym_valid = symValid;
    assign o_sym_last  = symValid & lastRead;
    assign o_sym_idx   = rdPtr_q;
    assign o_sym_re    = symValid ? rdData[2*WORD_SIZE-1:WORD_SIZE] : '0;
    assign o_sym_im    = symValid ? rdData[WORD_SIZE-1:0] : '0;
    assign o_frame_cnt = frameCnt_q;

endmodule

// File: tb/tb_qam4_frame_mapper.sv
// Randomized self-checking bench for qam4_frame_mapper against a frame-level model.
module tb_qam4_frame_mapper;

    logic        clk = 1'b0;
    logic        rstN;
    logic        bitIn;
    logic        bitValid;
    logic        bitReady;
    logic [15:0] cpRe [4];
    logic [15:0] cpIm [4];
    logic [15:0] symRe;
    logic [15:0] symIm;
    logic [3:0]  symIdx;
    logic        symValid;
    logic        symLast;
    logic        symReady;
    logic [7:0]  frameCnt;

    int checks = 0;
    int errors = 0;
    int expFrames = 0;

    always #5 clk = ~clk;

    qam4_frame_mapper dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_bit       (bitIn),
        .i_bit_valid (bitValid),
        .o_bit_ready (bitReady),
        .i_cp1_re    (cpRe[0]),
        .i_cp1_im    (cpIm[0]),
        .i_cp2_re    (cpRe[1]),
        .i_cp2_im    (cpIm[1]),
        .i_cp3_re    (cpRe[2]),
        .i_cp3_im    (cpIm[2]),
        .i_cp4_re    (cpRe[3]),
        .i_cp4_im    (cpIm[3]),
        .o_sym_re    (symRe),
        .o_sym_im    (symIm),
        .o_sym_idx   (symIdx),
        .o_sym_valid (symValid),
        .o_sym_last  (symLast),
        .i_sym_ready (symReady),
        .o_frame_cnt (frameCnt)
    );

    // Compare one observed value with its expected value and count it
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Gray table: {b1,b0} 00->cp1, 01->cp2, 11->cp3, 10->cp4
    function automatic int cpIndex(input logic b1, input logic b0);
        case ({b1, b0})
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic setReferenceCps();
        cpRe[0] = 16'h016A; cpIm[0] = 16'h00C9;
        cpRe[1] = 16'h016A; cpIm[1] = 16'hFF37;
        cpRe[2] = 16'hFE96; cpIm[2] = 16'hFF37;
        cpRe[3] = 16'hFE96; cpIm[3] = 16'h00C9;
    endtask

    task automatic setRandomCps();
        for (int k = 0; k < 4; k++) begin
            cpRe[k] = 16'($urandom);
            cpIm[k] = 16'($urandom);
        end
    endtask

    // Assert reset from the current time, check async clear, then release
    task automatic doReset();
        rstN     = 1'b0;
        bitValid = 1'b0;
        symReady = 1'b0;
        #1;
        checkOutput("rstBitReady", 32'(bitReady), 32'd0);
        checkOutput("rstSymValid", 32'(symValid), 32'd0);
        checkOutput("rstSymLast", 32'(symLast), 32'd0);
        checkOutput("rstSymIdx", 32'(symIdx), 32'd0);
        checkOutput("rstSymRe", 32'(symRe), 32'd0);
        checkOutput("rstSymIm", 32'(symIm), 32'd0);
        checkOutput("rstFrameCnt", 32'(frameCnt), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("rstHeldReady", 32'(bitReady), 32'd0);
        rstN = 1'b1;
        expFrames = 0;
        #1;
        checkOutput("releaseReady", 32'(bitReady), 32'd1);
    endtask

    // Push one frame of 32 bits, then drain and check all 16 symbols.
    // gapMode inserts random valid gaps; readyMode 0=always,1=1,0,0,1,2=random;
    // holdValid keeps toggling bits during drain; abortBits/abortIdx reset mid-frame.
    task automatic applyStimulus(input logic [31:0] bits, input int gapMode, input int readyMode,
                                 input bit holdValid, input int abortBits, input int abortIdx);
        logic [15:0] expRe [16];
        logic [15:0] expIm [16];
        logic [3:0]  rdyPat;
        int sent;
        int budget;
        int expIdx;
        int cyc;
        rdyPat = 4'b1001;
        for (int k = 0; k < 16; k++) begin
            expRe[k] = cpRe[cpIndex(bits[2*k], bits[2*k+1])];
            expIm[k] = cpIm[cpIndex(bits[2*k], bits[2*k+1])];
        end
        sent = 0;
        budget = 0;
        while (sent < 32 && sent != abortBits) begin
            @(negedge clk);
            checkOutput("fillSymValid", 32'(symValid), 32'd0);
            checkOutput("fillBitReady", 32'(bitReady), 32'd1);
            if (gapMode != 0 && $urandom_range(0, 2) == 0) begin
                bitValid = 1'b0;
            end else begin
                bitValid = 1'b1;
                bitIn    = bits[sent];
            end
            if (bitValid && bitReady) sent++;
            budget++;
            if (budget > 500) begin
                checkOutput("fillTimeout", 32'(sent), 32'd32);
                return;
            end
        end
        if (sent == abortBits) begin
            @(negedge clk);
            doReset();
            return;
        end
        expIdx = 0;
        cyc = 0;
        while (expIdx < 16) begin
            @(negedge clk);
            if (expIdx == abortIdx) begin
                doReset();
                return;
            end
            checkOutput("drainSymValid", 32'(symValid), 32'd1);
            checkOutput("drainBitReady", 32'(bitReady), 32'd0);
            checkOutput("drainSymIdx", 32'(symIdx), 32'(expIdx));
            checkOutput("drainSymRe", 32'(symRe), 32'(expRe[expIdx]));
            checkOutput("drainSymIm", 32'(symIm), 32'(expIm[expIdx]));
            checkOutput("drainSymLast", 32'(symLast), 32'(expIdx == 15));
            if (holdValid) begin
                bitValid = 1'b1;
                bitIn    = ~bitIn;
            end else begin
                bitValid = 1'b0;
            end
            case (readyMode)
                0:       symReady = 1'b1;
                1:       symReady = rdyPat[cyc % 4];
                default: symReady = 1'($urandom_range(0, 1));
            endcase
            if (symReady) expIdx++;
            cyc++;
            if (cyc > 500) begin
                checkOutput("drainTimeout", 32'(expIdx), 32'd16);
                return;
            end
        end
        @(negedge clk);
        expFrames = (expFrames + 1) % 256;
        checkOutput("postSymValid", 32'(symValid), 32'd0);
        checkOutput("postBitReady", 32'(bitReady), 32'd1);
        checkOutput("postFrameCnt", 32'(frameCnt), 32'(expFrames));
        bitValid = 1'b0;
    endtask

    function automatic logic [31:0] patternBits();
        logic [7:0] pat;
        logic [31:0] b;
        pat = 8'b01111000;
        for (int i = 0; i < 32; i++) b[i] = pat[i % 8];
        return b;
    endfunction

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] pat;
        pat = patternBits();
        rstN = 1'b0;
        bitIn = 1'b0;
        bitValid = 1'b0;
        symReady = 1'b0;
        setReferenceCps();
        doReset();

        $display("[TB] idle after reset");
        repeat (20) begin
            @(negedge clk);
            checkOutput("idleBitReady", 32'(bitReady), 32'd1);
            checkOutput("idleSymValid", 32'(symValid), 32'd0);
            checkOutput("idleFrameCnt", 32'(frameCnt), 32'd0);
        end

        $display("[TB] reference pattern, ready always");
        applyStimulus(pat, 0, 0, 1'b0, -1, -1);
        $display("[TB] reference pattern, ready 1,0,0,1");
        applyStimulus(pat, 0, 1, 1'b0, -1, -1);

        $display("[TB] valid held through drain");
        applyStimulus($urandom, 1, 2, 1'b1, -1, -1);
        applyStimulus(pat, 0, 0, 1'b0, -1, -1);

        $display("[TB] reset after 7 bits");
        applyStimulus($urandom, 0, 0, 1'b0, 7, -1);
        applyStimulus(pat, 0, 0, 1'b0, -1, -1);

        $display("[TB] reset at drain idx 9");
        applyStimulus(pat, 0, 0, 1'b0, -1, 9);
        applyStimulus(pat, 0, 0, 1'b0, -1, -1);

        $display("[TB] 256 random frames for counter wrap");
        @(negedge clk);
        doReset();
        for (int f = 0; f < 256; f++) begin
            setRandomCps();
            applyStimulus($urandom, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                          1'($urandom_range(0, 1)), -1, -1);
        end
        checkOutput("wrapFrameCnt", 32'(frameCnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qam4_frame_mapper.md
Name: qam4_frame_mapper

Overview:
- Sits directly downstream of the QAM4 constellation ROM and upstream of the 16-point IFFT/FFT input stage.
- Accepts a serial bit stream with a valid/ready handshake and Gray-maps each bit pair onto one of the four ROM constellation points.
- Collects N_SYM symbols into a frame buffer, then streams the frame out symbol by symbol with a valid/ready handshake and frame markers.

Parameters:
- WORD_SIZE, 16, width of each re/im component (two's complement, matches ROM output).
- N_SYM, 16, symbols per frame (FFT size); must be a power of two, at least 2.
- FRAME_CNT_W, 8, width of the completed-frame counter.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_bit  in  1  serial data bit
- i_bit_valid  in  1  i_bit is valid this cycle
- o_bit_ready  out  1  mapper accepts a bit this cycle
- i_cp1_re, i_cp1_im  in  WORD_SIZE each  constellation point 1 (++ quadrant)
- i_cp2_re, i_cp2_im  in  WORD_SIZE each  constellation point 2 (+- quadrant)
- i_cp3_re, i_cp3_im  in  WORD_SIZE each  constellation point 3 (-- quadrant)
- i_cp4_re, i_cp4_im  in  WORD_SIZE each  constellation point 4 (-+ quadrant)
- o_sym_re, o_sym_im  out  WORD_SIZE each  output symbol
- o_sym_idx  out  log2(N_SYM)  index of the output symbol within its frame
- o_sym_valid  out  1  output symbol is valid
- o_sym_last  out  1  high with o_sym_valid when o_sym_idx = N_SYM-1
- i_sym_ready  in  1  consumer accepts the symbol
- o_frame_cnt  out  FRAME_CNT_W  number of fully drained frames; wraps to 0

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - State goes to FILL; write pointer, read pointer and pair phase go to 0; any half-collected pair is discarded.
  - All buffer entries clear to 0; o_frame_cnt clears to 0.
  - o_sym_valid = 0, o_sym_last = 0, o_sym_idx = 0, o_sym_re = o_sym_im = 0.
  - o_bit_ready = 0 while in reset, 1 on the first cycle after release.
- Bit acceptance occurs when i_bit_valid and o_bit_ready are both high.
  - First accepted bit of a pair is stored as b1 (MSB).
  - Second accepted bit is b0; the pair completes on that cycle.
  - Gaps in i_bit_valid between or within pairs are allowed.
- Gray mapping of {b1,b0}: 00 gives cp1, 01 gives cp2, 11 gives cp3, 10 gives cp4.
  - The cp inputs are sampled on the cycle the pair completes.
  - The mapped value is written to buffer[wr_ptr] at the next clock edge, and wr_ptr increments.
- FSM, two states:
  - FILL: o_bit_ready = 1, o_sym_valid = 0. When the pair completing this cycle writes entry N_SYM-1, go to DRAIN next cycle, wr_ptr wraps to 0, o_bit_ready drops.
  - DRAIN: o_bit_ready = 0. o_sym_valid = 1. o_sym_re/im = buffer[rd_ptr], read combinationally from the flop array. o_sym_idx = rd_ptr.
  - In DRAIN, a transfer (o_sym_valid and i_sym_ready) increments rd_ptr. A transfer at rd_ptr = N_SYM-1 sets rd_ptr to 0, increments o_frame_cnt (wrapping at 2^FRAME_CNT_W), and returns to FILL next cycle.
  - While i_sym_ready is low, the outputs hold stable.
- Latency:
  - The last bit of a frame accepted at cycle t gives o_sym_valid = 1 at t+1.
  - The final symbol transfer at cycle t gives o_bit_ready = 1 at t+1.
  - Minimum period per frame is 2*N_SYM + N_SYM cycles.
- Boundary conditions:
  - No simultaneous fill and drain; the input is stalled during DRAIN.
  - A pair never straddles frames.
  - i_bit_valid during DRAIN has no effect.
  - Reset mid-DRAIN abandons the frame; o_frame_cnt does not increment for it.

Decomposition:
- Shared package qam4_pkg holds:
  - N_SYM and WORD_SIZE defaults.
  - The 2-bit Gray code constants GRAY_CP1..GRAY_CP4 (00, 01, 11, 10).
  - The FSM state encoding FILL/DRAIN.
- One sub-module, qam4_symbol_buffer: an N_SYM x 2*WORD_SIZE flop array with asynchronous active-low clear, one synchronous write port and one combinational read port.

Test Plan:
- Reset release with cp inputs at ±0x016A / ±0x00C9 and no bits -> o_bit_ready = 1, o_sym_valid = 0, o_frame_cnt = 0 indefinitely.
- 32 bits of pattern 00,01,11,10 repeated, i_sym_ready = 1:
  - o_sym_valid rises the cycle after bit 32.
  - idx 0..15 cycle through re/im = 016A/00C9, 016A/FF37, FE96/FF37, FE96/00C9.
  - o_sym_last only at idx 15.
  - o_frame_cnt = 1.
  - o_bit_ready returns the cycle after.
- Same frame with i_sym_ready toggled 1,0,0,1:
  - Outputs hold during stalls.
  - Exactly 16 transfers occur, with no duplicate or skipped idx.
- i_bit_valid held high through DRAIN with alternating bits -> none accepted; the next frame begins cleanly with b1 of a new pair.
- Reset asserted after 7 bits, and separately at idx 9 of DRAIN:
  - After release, a fresh 32-bit frame maps from idx 0.
  - o_frame_cnt excludes the aborted frame.
- 256 back-to-back frames -> o_frame_cnt wraps 255 to 0.
